muldiv_unit: RTL and testbench

Iterative multiply/divide unit for the MIPS execute stage. It handles MULT, MULTU, DIV, DIVU, MTHI and MTLO, which the single-cycle ALU does not cover. It owns the architectural HI/LO registers and sits beside the ALU with a start/busy/done handshake. The hazard unit stalls MFHI/MFLO while busy=1.

---
 rtl/muldiv_if.sv | 30 +++
 rtl/muldiv_unit.sv | 178 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
//
// Handshake: the requester raises start for one cycle with op/a/b stable; the
// unit samples it only on a rising edge where busy=0. A mul/div request raises
// busy on that same edge and holds it until the result is written; done pulses
// for exactly one cycle when hi/lo have just been updated. A start seen while
// busy=1 is dropped, not queued. A new start may be issued in the done cycle.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [1:0]       dbg_state;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo, dbg_state
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo, dbg_state
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// One result bit per cycle: shift-add multiply, restoring divide, then a
// single sign-fixup cycle before HI/LO are written.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    muldiv_if.slave  bus
);
    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   opa_q, opa_d;      // multiplicand magnitude
    logic [WIDTH-1:0]   opb_q, opb_d;      // multiplier (shifted) or divisor magnitude
    logic [2*WIDTH-1:0] acc_q, acc_d;      // product, or {remainder, dividend/quotient}
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;      // negate product / quotient
    logic               rem_neg_q, rem_neg_d;
    logic               dz_q, dz_d;        // divide by zero
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               a_sgn, b_sgn;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo, rem;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: only mul/div ops leave IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start && !bus.op[2]) state_d = CALC;
            CALC:    if (cnt_q == LAST) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        bus.busy      = (state_q != IDLE);
        bus.dbg_state = state_q;
        bus.done      = done_q;
        bus.hi        = hi_q;
        bus.lo        = lo_q;
    end

    // Datapath: operand capture, one iteration per CALC cycle, sign fixup and writeback
    always_comb begin
        cnt_d     = cnt_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        acc_d     = acc_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        dz_d      = dz_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;

        // op[0]=0 selects the signed variants (MULT, DIV)
        a_sgn = !bus.op[0] && bus.a[WIDTH-1];
        b_sgn = !bus.op[0] && bus.b[WIDTH-1];
        a_mag = a_sgn ? -bus.a : bus.a;
        b_mag = b_sgn ? -bus.b : bus.b;

        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (opb_q[0] ? opa_q : '0)};
        rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff    = rem_sh - {1'b0, opb_q};

        prod_fix = neg_q ? -acc_q : acc_q;
        quo      = acc_q[WIDTH-1:0];
        rem      = acc_q[2*WIDTH-1:WIDTH];

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            is_div_d  = bus.op[1];
                            neg_d     = a_sgn ^ b_sgn;
                            rem_neg_d = a_sgn;
                            dz_d      = bus.op[1] && (bus.b == '0);
                            opa_d     = a_mag;
                            opb_d     = b_mag;
                            cnt_d     = '0;
                            // divide keeps the dividend in the low half and shifts it out MSB-first
                            acc_d     = bus.op[1] ? {{WIDTH{1'b0}}, a_mag} : '0;
                        end
                        3'd4: begin
                            hi_d   = bus.a;
                            done_d = 1'b1;
                        end
                        3'd5: begin
                            lo_d   = bus.a;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            CALC: begin
                cnt_d = cnt_q + CW'(1);
                if (is_div_q) begin
                    // remainder < divisor always fits WIDTH bits on either branch
                    if (!diff[WIDTH]) acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    else              acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end else begin
                    // add into the top half, then shift the whole product right
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    opb_d = opb_q >> 1;
                end
            end
            FIX: begin
                cnt_d  = '0;
                done_d = 1'b1;
                if (is_div_q) begin
                    lo_d = dz_q ? '1 : (neg_q ? -quo : quo);
                    hi_d = rem_neg_q ? -rem : rem;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            acc_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            cnt_q     <= cnt_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            acc_q     <= acc_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            dz_q      <= dz_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: directed cases plus random ops against an
// arithmetic reference model, checked by a done-driven monitor.
module tb_muldiv_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(W)) bus();

    muldiv_unit #(.WIDTH(W), .ITER(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [2*W-1:0] exp_q[$];
    int             done_cyc_q[$];
    int             vectors = 0;
    int             miscompares = 0;
    int             cyc = 0;
    logic [W-1:0]   m_hi = '0;
    logic [W-1:0]   m_lo = '0;
    logic [2*W-1:0] committed = '0;
    logic           checking = 1'b0;
    int             busy_s = -1;
    int             busy_e = -2;
    logic [2*W-1:0] mon_e;
    int             mon_dc;

    // clock / cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain signed/unsigned arithmetic on 64-bit values
    function automatic logic [2*W-1:0] ref_result(input logic [2:0] o, input logic [W-1:0] av,
                                                   input logic [W-1:0] bv, input logic [W-1:0] hi0,
                                                   input logic [W-1:0] lo0);
        longint sa, sb, q, r;
        logic [2*W-1:0] p;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        p  = {hi0, lo0};
        case (o)
            3'd0: p = sa * sb;
            3'd1: p = {32'b0, av} * {32'b0, bv};
            3'd2: begin
                if (bv == 0) p = {av, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            3'd3: p = (bv == 0) ? {av, 32'hFFFF_FFFF} : {av % bv, av / bv};
            3'd4: p = {av, lo0};
            3'd5: p = {hi0, av};
            default: p = {hi0, lo0};
        endcase
        return p;
    endfunction

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return W'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // driver: called just after a rising edge; waits for idle, then issues one request
    task automatic issue(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
        int guard;
        int e0;
        logic [2*W-1:0] e;
        guard = 0;
        while (bus.busy && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 200) begin
            vectors++;
            miscompares++;
            $display("FAIL issue_wait: busy still %0d after %0d cycles, required 0", bus.busy, guard);
        end
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = av;
        bus.b     = bv;
        @(posedge clk);
        #1;
        e0 = cyc;
        bus.start = 1'b0;
        bus.op    = 3'($urandom_range(0, 7));
        bus.a     = $urandom;
        bus.b     = $urandom;
        if (o <= 3'd5) begin
            e = ref_result(o, av, bv, m_hi, m_lo);
            m_hi = e[2*W-1:W];
            m_lo = e[W-1:0];
            exp_q.push_back(e);
            done_cyc_q.push_back((o <= 3'd3) ? e0 + 33 : e0);
            if (o <= 3'd3) begin
                busy_s = e0;
                busy_e = e0 + 32;
            end
        end
    endtask

    // driver: start pulse that the model expects to be ignored
    task automatic pulse_ignored(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = av;
        bus.b     = bv;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((bus.busy || exp_q.size() != 0) && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 200) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_idle: %0d results outstanding after %0d cycles, required 0", exp_q.size(), guard);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // scoreboard monitor: pops an expected result on every done pulse
    always @(negedge clk) begin
        if (rst_n && checking) begin
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done: done=1 with hi=%h lo=%h, required no done", bus.hi, bus.lo);
                end else begin
                    mon_e  = exp_q.pop_front();
                    mon_dc = done_cyc_q.pop_front();
                    check("result", {bus.hi, bus.lo}, mon_e);
                    check("done_cycle", 64'(cyc), 64'(mon_dc));
                    committed = mon_e;
                end
            end else begin
                check("hold", {bus.hi, bus.lo}, committed);
            end
            check("busy", 64'(bus.busy), 64'(cyc >= busy_s && cyc <= busy_e));
        end
    end

    initial begin
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.a     = '0;
        bus.b     = '0;

        #1 rst_n = 1'b0;
        #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        check("rst_state", 64'(bus.dbg_state), 64'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        checking = 1'b1;

        issue(3'd0, 32'd12, 32'hFFFF_FFDE);
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        issue(3'd3, 32'd100, 32'd0);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(3'd2, 32'hFFFF_FFF9, 32'd0);
        wait_idle();
        issue(3'd4, 32'h1234, 32'd0);
        issue(3'd5, 32'h5678, 32'd0);
        issue(3'd6, 32'hDEAD, 32'd1);
        wait_idle();

        issue(3'd0, 32'd5, 32'd6);
        repeat (8) @(posedge clk);
        #1;
        pulse_ignored(3'd3, 32'd9, 32'd3);
        wait_idle();

        for (int i = 0; i < 40; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                #1;
            end
            issue(3'($urandom_range(0, 7)), rand_operand(), rand_operand());
        end
        wait_idle();

        issue(3'd0, 32'd5, 32'd6);
        repeat (14) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_hilo", {bus.hi, bus.lo}, 64'd0);
        check("abort_state", 64'(bus.dbg_state), 64'd0);
        exp_q.delete();
        done_cyc_q.delete();
        m_hi = '0;
        m_lo = '0;
        committed = '0;
        busy_s = -1;
        busy_e = -2;
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (50) @(posedge clk);
        #1;

        issue(3'd1, 32'd7, 32'd9);
        wait_idle();

        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL leftover: %0d results never completed, required 0", exp_q.size());
        end
        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
